// File: rtl/pa_pc_pkg.sv
// Shared types for the PA-RISC PC queue: FSM states, defaults and the redirect record.
package pa_pc_pkg;
    localparam int PC_W_DEF = 8;
    localparam int STEP_DEF = 4;
    localparam int PC_W_MAX = 32;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    // Target is held at the widest supported PC; users take the low PC_W bits.
    typedef struct packed {
        logic                valid;
        logic [PC_W_MAX-1:0] target;
        logic                nullify;
    } redirect_t;

    function automatic logic [PC_W_MAX-1:0] align4(input logic [PC_W_MAX-1:0] t);
        return {t[PC_W_MAX-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer: captures branch targets that cannot be applied yet,
// checks word alignment and selects between the live and buffered redirect.
module pc_redirect_buf
    import pa_pc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            live_taken,
    input  logic            live_nullify,
    input  logic [PC_W-1:0] live_target,
    input  logic            capture_en,
    input  logic            advance,
    output logic            sel_valid,
    output logic [PC_W-1:0] sel_target,
    output logic            sel_nullify,
    output logic            align_err
);
    redirect_t pend;
    redirect_t live_rd;
    redirect_t sel;

    assign live_rd = '{valid:   live_taken,
                       target:  align4(PC_W_MAX'(live_target)),
                       nullify: live_nullify};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            align_err <= 1'b0;
        end else begin
            align_err <= live_taken & capture_en & (|live_target[1:0]);
            // Applying any redirect empties the buffer; otherwise newest branch wins.
            if (advance)
                pend <= '0;
            else if (live_taken && capture_en)
                pend <= live_rd;
        end
    end

    assign sel         = live_taken ? live_rd : pend;
    assign sel_valid   = sel.valid;
    assign sel_target  = sel.target[PC_W-1:0];
    assign sel_nullify = sel.nullify;
endmodule

// File: rtl/pc_queue_ctrl.sv
// PA-RISC PC queue (front/back) with fetch handshake and delayed-branch redirect.
module pc_queue_ctrl
    import pa_pc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              STEP     = STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            fetch_ack,
    input  logic            branch_taken,
    input  logic            branch_nullify,
    input  logic [PC_W-1:0] tag_target,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc_front,
    output logic [PC_W-1:0] pc_back,
    output logic            null_front,
    output logic            align_err
);
    state_t          state, state_nxt;
    logic            advance;
    logic            sel_valid;
    logic [PC_W-1:0] sel_target;
    logic            sel_nullify;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = enable ? RUN : HOLD;
            HOLD:    state_nxt = enable ? RUN : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_req = (state == RUN);
    end

    assign advance = (state == RUN) & fetch_ack & enable;

    pc_redirect_buf #(.PC_W(PC_W)) u_rbuf (
        .clk          (clk),
        .rst          (reset),
        .live_taken   (branch_taken),
        .live_nullify (branch_nullify),
        .live_target  (tag_target),
        .capture_en   (state != IDLE),
        .advance      (advance),
        .sel_valid    (sel_valid),
        .sel_target   (sel_target),
        .sel_nullify  (sel_nullify),
        .align_err    (align_err)
    );

    // The delay slot (old pc_back) always moves to the front, redirect or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_front   <= RESET_PC;
            pc_back    <= RESET_PC + PC_W'(STEP);
            null_front <= 1'b0;
        end else if (advance) begin
            pc_front <= pc_back;
            if (sel_valid) begin
                pc_back    <= sel_target;
                null_front <= sel_nullify;
            end else begin
                pc_back    <= pc_back + PC_W'(STEP);
                null_front <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_queue_ctrl.sv
// Directed bench for pc_queue_ctrl with a cycle-level reference model and literal checkpoints.
module tb_pc_queue_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       fetch_ack = 1'b0;
    logic       branch_taken = 1'b0;
    logic       branch_nullify = 1'b0;
    logic [7:0] tag_target = 8'h00;
    logic       fetch_req;
    logic [7:0] pc_front, pc_back;
    logic       null_front, align_err;

    int checks = 0;
    int failures = 0;

    pc_queue_ctrl #(.PC_W(8), .RESET_PC(8'h00), .STEP(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fetch_ack(fetch_ack),
        .branch_taken(branch_taken), .branch_nullify(branch_nullify),
        .tag_target(tag_target), .fetch_req(fetch_req), .pc_front(pc_front),
        .pc_back(pc_back), .null_front(null_front), .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset, enable seen at the last edge, pending redirect.
    int         m_edges;
    logic       m_prev_en;
    logic [7:0] m_front, m_back;
    logic       m_null, m_ae;
    logic       p_valid, p_null;
    logic [7:0] p_tgt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edges = 0; m_prev_en = 1'b0;
            m_front = 8'h00; m_back = 8'h04; m_null = 1'b0; m_ae = 1'b0;
            p_valid = 1'b0; p_null = 1'b0; p_tgt = 8'h00;
        end else begin
            logic fetching, adv, started;
            fetching = (m_edges == 1) || (m_edges >= 2 && m_prev_en);
            started  = (m_edges >= 1);
            adv      = fetching && fetch_ack && enable;
            m_ae     = started && branch_taken && (tag_target % 4 != 0);
            if (adv) begin
                m_front = m_back;
                if (branch_taken) begin
                    m_back = tag_target - (tag_target % 4); m_null = branch_nullify;
                end else if (p_valid) begin
                    m_back = p_tgt; m_null = p_null;
                end else begin
                    m_back = m_back + 8'd4; m_null = 1'b0;
                end
                p_valid = 1'b0;
            end else if (started && branch_taken) begin
                p_valid = 1'b1; p_tgt = tag_target - (tag_target % 4); p_null = branch_nullify;
            end
            m_prev_en = enable;
            if (m_edges < 1000) m_edges++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model fetch_req", 32'(fetch_req),
                32'((m_edges == 1) || (m_edges >= 2 && m_prev_en)));
            chk("model pc_front", 32'(pc_front), 32'(m_front));
            chk("model pc_back", 32'(pc_back), 32'(m_back));
            chk("model null_front", 32'(null_front), 32'(m_null));
            chk("model align_err", 32'(align_err), 32'(m_ae));
        end
    end

    task automatic cyc(input logic ack, input logic en, input logic bt,
                       input logic bn, input logic [7:0] tgt);
        fetch_ack = ack; enable = en; branch_taken = bt;
        branch_nullify = bn; tag_target = tgt;
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        chk("reset pc_front", 32'(pc_front), 32'h00);
        chk("reset pc_back", 32'(pc_back), 32'h04);
        chk("reset fetch_req", 32'(fetch_req), 32'h0);

        cyc(1, 1, 0, 0, 8'h00);
        chk("first fetch_req", 32'(fetch_req), 32'h1);
        chk("no advance in idle", 32'({pc_front, pc_back}), 32'h0004);
        cyc(1, 1, 0, 0, 8'h00);
        chk("seq step1", 32'({pc_front, pc_back}), 32'h0408);
        cyc(1, 1, 0, 0, 8'h00);
        chk("seq step2", 32'({pc_front, pc_back}), 32'h080C);

        cyc(1, 1, 1, 1, 8'h40);
        chk("branch live pcs", 32'({pc_front, pc_back}), 32'h0C40);
        chk("branch live null", 32'(null_front), 32'h1);
        cyc(1, 1, 0, 0, 8'h00);
        chk("after branch pcs", 32'({pc_front, pc_back}), 32'h4044);
        chk("after branch null", 32'(null_front), 32'h0);

        cyc(1, 0, 0, 0, 8'h00);
        chk("stall frozen", 32'({pc_front, pc_back}), 32'h4044);
        chk("stall fetch_req", 32'(fetch_req), 32'h0);
        cyc(1, 0, 1, 0, 8'h20);
        cyc(1, 0, 0, 0, 8'h00);
        chk("stall buffered frozen", 32'({pc_front, pc_back}), 32'h4044);
        cyc(1, 1, 0, 0, 8'h00);
        chk("hold exit no advance", 32'({pc_front, pc_back}), 32'h4044);
        cyc(1, 1, 0, 0, 8'h00);
        chk("buffered applied", 32'({pc_front, pc_back}), 32'h4420);

        cyc(0, 1, 1, 0, 8'h30);
        cyc(0, 1, 1, 0, 8'h50);
        chk("no ack frozen", 32'({pc_front, pc_back}), 32'h4420);
        cyc(1, 1, 0, 0, 8'h00);
        chk("newest wins", 32'({pc_front, pc_back}), 32'h2050);
        cyc(1, 1, 0, 0, 8'h00);
        chk("buffer empty", 32'({pc_front, pc_back}), 32'h5054);

        cyc(1, 1, 1, 0, 8'h43);
        chk("misaligned target", 32'({pc_front, pc_back}), 32'h5440);
        chk("align_err pulse", 32'(align_err), 32'h1);
        cyc(1, 1, 0, 0, 8'h00);
        chk("align_err clears", 32'(align_err), 32'h0);

        cyc(1, 1, 1, 0, 8'hFC);
        chk("to FC", 32'(pc_back), 32'hFC);
        cyc(1, 1, 0, 0, 8'h00);
        chk("wrap", 32'({pc_front, pc_back}), 32'hFC00);

        cyc(0, 1, 1, 1, 8'h80);
        reset = 1'b1; #1;
        chk("async reset pcs", 32'({pc_front, pc_back}), 32'h0004);
        chk("async reset fetch_req", 32'(fetch_req), 32'h0);
        chk("async reset null", 32'(null_front), 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        chk("redirect discarded", 32'({pc_front, pc_back}), 32'h080C);
        chk("null after reset", 32'(null_front), 32'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
